pipelined_mac: RTL and testbench

Parametrised, DSP48-mappable multiply-accumulate: successor to the single-shot combinational multiplier in the DSP test designs. Accepts a stream of operand pairs under a valid/ready handshake, runs a fixed three-stage pipeline (operand, product, accumulator registers, matching DSP48E1 AREG/BREG, MREG, PREG) and emits a running sum per accepted sample. Supports signed or unsigned operands, per-stream restart and a sticky overflow flag. Sits between board-level operand sources and the result pins / downstream logic in the DSP test tops.

---
 rtl/dsp_pkg.sv | 42 ++++
 rtl/mac_core.sv | 124 ++++++++++++
 rtl/pipelined_mac.sv | 98 +++++++++
 tb/tb_pipelined_mac.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP MAC blocks: pipeline latency, the
// accumulator overflow rule and an elaboration-time width check.
package dsp_pkg;

  // Operand, product and accumulator registers (AREG/BREG, MREG, PREG)
  localparam int unsigned MAC_LATENCY = 3;

  // Largest operand widths that still map onto a single DSP48E1 multiplier
  localparam int unsigned A_WIDTH_MAX = 25;
  localparam int unsigned B_WIDTH_MAX = 18;

  // Overflow of one accumulator addition.
  // Unsigned: carry out of the MSB.
  // Signed: both addends share a sign and the sum's sign differs from it.
  function automatic logic add_ovf(
    input logic is_signed,
    input logic a_msb,
    input logic b_msb,
    input logic sum_msb,
    input logic carry
  );
    logic ovf;
    if (is_signed) begin
      ovf = (a_msb == b_msb) && (sum_msb != a_msb);
    end else begin
      ovf = carry;
    end
    return ovf;
  endfunction

endpackage

// Elaboration-time guard on operand/accumulator widths; expands to a
// generate block, so use it in a module body.
`ifndef DSP_WIDTH_CHECK
`define DSP_WIDTH_CHECK(AW, BW, ACCW) \
  if (((AW) < 1) || ((AW) > dsp_pkg::A_WIDTH_MAX) || \
      ((BW) < 1) || ((BW) > dsp_pkg::B_WIDTH_MAX) || \
      ((ACCW) < (AW) + (BW))) begin : g_width_check \
    $error("DSP MAC: illegal widths A=%0d B=%0d ACC=%0d", AW, BW, ACCW); \
  end
`endif

// File: rtl/mac_core.sv
// Three-stage multiply-accumulate datapath, shaped for DSP48 inference.
//   stage 1: operand registers (a, b, first, last, valid)
//   stage 2: product register m = a*b
//   stage 3: accumulator P and sticky overflow
// All registers, valid bits included, advance only while i_ce is high.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_ce                pipeline enable
//   i_valid/i_first/i_last, i_a, i_b   sample entering stage 1
//   o_valid, o_last     stage-3 valid and last flag
//   o_acc, o_ovf        accumulator P and sticky overflow
module mac_core
  import dsp_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 48,
  parameter bit          SIGNED    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_ce,
  input  logic                 i_valid,
  input  logic                 i_first,
  input  logic                 i_last,
  input  logic [A_WIDTH-1:0]   i_a,
  input  logic [B_WIDTH-1:0]   i_b,
  output logic                 o_valid,
  output logic                 o_last,
  output logic [ACC_WIDTH-1:0] o_acc,
  output logic                 o_ovf
);

  localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;

  `DSP_WIDTH_CHECK(A_WIDTH, B_WIDTH, ACC_WIDTH)

  // Stage 1
  logic               r_v1;
  logic               r_f1;
  logic               r_l1;
  logic [A_WIDTH-1:0] r_a;
  logic [B_WIDTH-1:0] r_b;

  // Stage 2
  logic               r_v2;
  logic               r_f2;
  logic               r_l2;
  logic [P_WIDTH-1:0] r_m;

  // Stage 3
  logic                 r_v3;
  logic                 r_l3;
  logic [ACC_WIDTH-1:0] r_p;
  logic                 r_ovf;

  logic [P_WIDTH-1:0]   w_prod;
  logic [ACC_WIDTH-1:0] w_m_ext;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_ovf;

  // Full-width product and extension to the accumulator width
  if (SIGNED) begin : g_signed
    assign w_prod  = P_WIDTH'(signed'(r_a)) * P_WIDTH'(signed'(r_b));
    assign w_m_ext = ACC_WIDTH'(signed'(r_m));
  end else begin : g_unsigned
    assign w_prod  = P_WIDTH'(r_a) * P_WIDTH'(r_b);
    assign w_m_ext = ACC_WIDTH'(r_m);
  end

  // Accumulate with one extra bit to expose the unsigned carry
  assign w_sum = {1'b0, r_p} + {1'b0, w_m_ext};
  assign w_ovf = add_ovf(SIGNED, r_p[ACC_WIDTH-1], w_m_ext[ACC_WIDTH-1],
                         w_sum[ACC_WIDTH-1], w_sum[ACC_WIDTH]);

  // Pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_f1  <= 1'b0;
      r_l1  <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_v2  <= 1'b0;
      r_f2  <= 1'b0;
      r_l2  <= 1'b0;
      r_m   <= '0;
      r_v3  <= 1'b0;
      r_l3  <= 1'b0;
      r_p   <= '0;
      r_ovf <= 1'b0;
    end else if (i_ce) begin
      r_v1 <= i_valid;
      r_f1 <= i_first;
      r_l1 <= i_last;
      r_a  <= i_a;
      r_b  <= i_b;

      r_v2 <= r_v1;
      r_f2 <= r_f1;
      r_l2 <= r_l1;
      r_m  <= w_prod;

      // A bubble leaves P and overflow untouched
      r_v3 <= r_v2;
      if (r_v2) begin
        r_l3 <= r_l2;
        if (r_f2) begin
          r_p   <= w_m_ext;
          r_ovf <= 1'b0;
        end else begin
          r_p   <= w_sum[ACC_WIDTH-1:0];
          r_ovf <= r_ovf | w_ovf;
        end
      end
    end
  end

  assign o_valid = r_v3;
  assign o_last  = r_l3;
  assign o_acc   = r_p;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/pipelined_mac.sv
// Streaming multiply-accumulate with valid/ready handshake. Wraps mac_core
// with the clock input buffer, the global stall enable and a registered
// output view of the accumulator stage.
// Ports:
//   clk_p, clk_n        differential clock
//   rst_n               async active-low reset
//   in_valid/in_ready   input handshake; in_first restarts the sum,
//                       in_last marks the end of an accumulation
//   factor_a, factor_b  operands
//   out_valid/out_ready output handshake
//   out_last            in_last of the sample behind this result
//   result              running sum
//   overflow            sticky overflow since the last in_first
module pipelined_mac
  import dsp_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 48,
  parameter bit          SIGNED    = 1'b0
) (
  input  logic                 clk_p,
  input  logic                 clk_n,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [A_WIDTH-1:0]   factor_a,
  input  logic [B_WIDTH-1:0]   factor_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow
);

  logic                 w_clk;
  logic                 w_ce;
  logic                 w_core_valid;
  logic                 w_core_last;
  logic [ACC_WIDTH-1:0] w_core_acc;
  logic                 w_core_ovf;

  logic                 r_out_valid;
  logic                 r_out_last;
  logic [ACC_WIDTH-1:0] r_result;
  logic                 r_overflow;

  // Behavioural stand-in for IBUFDS -> BUFG; with complementary legs this
  // is simply clk_p
  assign w_clk = clk_p & ~clk_n;

  // A held result stalls everything; no skid buffer, so in_ready follows
  assign w_ce     = !(r_out_valid && !out_ready);
  assign in_ready = w_ce;

  mac_core #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .SIGNED   (SIGNED)
  ) u_core (
    .clk    (w_clk),
    .rst_n  (rst_n),
    .i_ce   (w_ce),
    .i_valid(in_valid),
    .i_first(in_first),
    .i_last (in_last),
    .i_a    (factor_a),
    .i_b    (factor_b),
    .o_valid(w_core_valid),
    .o_last (w_core_last),
    .o_acc  (w_core_acc),
    .o_ovf  (w_core_ovf)
  );

  // Registered output view of the accumulator stage
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
    end else if (w_ce) begin
      r_out_valid <= w_core_valid;
      r_out_last  <= w_core_valid & w_core_last;
      r_result    <= w_core_acc;
      r_overflow  <= w_core_ovf;
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign result    = r_result;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_pipelined_mac.sv
// Bench for pipelined_mac: three instances share one stimulus stream
// (unsigned/48, signed/48, unsigned/16). A transaction-level model computes
// each expected running sum when a sample is accepted; results are checked
// in order as they leave each instance. Directed steps pin down latency,
// back-pressure, overflow and reset behaviour.
`timescale 1ns/1ps
module tb_pipelined_mac;

  logic clk_p = 1'b0;
  logic clk_n;
  assign clk_n = ~clk_p;
  always #5 clk_p = ~clk_p;

  logic        rst_n;
  logic        in_valid;
  logic        in_first;
  logic        in_last;
  logic [7:0]  fa;
  logic [7:0]  fb;
  logic        out_ready;

  logic        rdy_u, ov_u, ol_u, of_u;
  logic [47:0] res_u;
  logic        rdy_s, ov_s, ol_s, of_s;
  logic [47:0] res_s;
  logic        rdy_o, ov_o, ol_o, of_o;
  logic [15:0] res_o;

  pipelined_mac #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(48), .SIGNED(1'b0)) u_mac_u (
    .clk_p(clk_p), .clk_n(clk_n), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy_u), .in_first(in_first), .in_last(in_last),
    .factor_a(fa), .factor_b(fb),
    .out_valid(ov_u), .out_ready(out_ready), .out_last(ol_u),
    .result(res_u), .overflow(of_u));

  pipelined_mac #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(48), .SIGNED(1'b1)) u_mac_s (
    .clk_p(clk_p), .clk_n(clk_n), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy_s), .in_first(in_first), .in_last(in_last),
    .factor_a(fa), .factor_b(fb),
    .out_valid(ov_s), .out_ready(out_ready), .out_last(ol_s),
    .result(res_s), .overflow(of_s));

  pipelined_mac #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1'b0)) u_mac_o (
    .clk_p(clk_p), .clk_n(clk_n), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy_o), .in_first(in_first), .in_last(in_last),
    .factor_a(fa), .factor_b(fb),
    .out_valid(ov_o), .out_ready(out_ready), .out_last(ol_o),
    .result(res_o), .overflow(of_o));

  typedef struct {
    logic [47:0] res;
    logic        last;
    logic        ovf;
  } exp_t;

  exp_t   q_u[$];
  exp_t   q_s[$];
  exp_t   q_o[$];
  longint m_acc[3];
  bit     m_ovf[3];
  int     n_tests;
  int     n_fail;
  int     n_acc;

  // Running-sum model: k=0 unsigned/48, k=1 signed/48, k=2 unsigned/16
  function automatic exp_t model_step(input int k, input logic [7:0] a, input logic [7:0] b,
                                      input logic first, input logic last);
    longint p;
    longint s;
    longint lim;
    bit     o;
    exp_t   e;
    if (k == 1) p = longint'($signed(a)) * longint'($signed(b));
    else        p = longint'(a) * longint'(b);
    if (first) begin
      m_acc[k] = p;
      m_ovf[k] = 1'b0;
    end else begin
      s = m_acc[k] + p;
      o = 1'b0;
      if (k == 1) begin
        lim = longint'(1) << 47;
        if (s >= lim) begin
          o = 1'b1; s = s - 2 * lim;
        end else if (s < -lim) begin
          o = 1'b1; s = s + 2 * lim;
        end
      end else begin
        lim = (k == 0) ? (longint'(1) << 48) : longint'(65536);
        if (s >= lim) begin
          o = 1'b1; s = s - lim;
        end
      end
      m_acc[k] = s;
      m_ovf[k] = m_ovf[k] | o;
    end
    e.res  = 48'(m_acc[k]);
    e.last = last;
    e.ovf  = m_ovf[k];
    return e;
  endfunction

  function automatic int q_size(input int k);
    case (k)
      0:       return q_u.size();
      1:       return q_s.size();
      default: return q_o.size();
    endcase
  endfunction

  function automatic exp_t q_pop(input int k);
    case (k)
      0:       return q_u.pop_front();
      1:       return q_s.pop_front();
      default: return q_o.pop_front();
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare one delivered result of instance k against the model queue
  task automatic score(input int k, input string nm, input logic [47:0] r,
                       input logic l, input logic o);
    exp_t e;
    n_tests++;
    assert (q_size(k) > 0) else begin
      n_fail++;
      $error("FAIL %s_extra_result: observed %0h expected no result", nm, r);
    end
    if (q_size(k) > 0) begin
      e = q_pop(k);
      check({nm, "_result"}, 64'(r), 64'(e.res));
      check({nm, "_last"},   64'(l), 64'(e.last));
      check({nm, "_ovf"},    64'(o), 64'(e.ovf));
    end
  endtask

  // One clock: observe handshakes mid-cycle, then step past the edge
  task automatic tick();
    @(negedge clk_p);
    if (rst_n) begin
      if (in_valid && rdy_u) begin
        q_u.push_back(model_step(0, fa, fb, in_first, in_last));
        q_s.push_back(model_step(1, fa, fb, in_first, in_last));
        q_o.push_back(model_step(2, fa, fb, in_first, in_last));
        n_acc++;
      end
      if (ov_u && out_ready) score(0, "u", res_u, ol_u, of_u);
      if (ov_s && out_ready) score(1, "s", res_s, ol_s, of_s);
      if (ov_o && out_ready) score(2, "o", 48'(res_o), ol_o, of_o);
    end
    @(posedge clk_p);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic f, input logic l);
    in_valid = v;
    fa       = a;
    fb       = b;
    in_first = f;
    in_last  = l;
  endtask

  task automatic flush_model();
    q_u.delete();
    q_s.delete();
    q_o.delete();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(4))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int start;
    int cyc;
    n_tests = 0;
    n_fail  = 0;
    n_acc   = 0;
    flush_model();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (2) tick();

    // Reset state
    check("rst_result",   64'(res_u), 64'd0);
    check("rst_valid",    64'(ov_u),  64'd0);
    check("rst_last",     64'(ol_u),  64'd0);
    check("rst_overflow", 64'(of_u),  64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ready_u", 64'(rdy_u), 64'd1);
    check("rst_ready_s", 64'(rdy_s), 64'd1);
    check("rst_ready_o", 64'(rdy_o), 64'd1);
    tick();

    // Unsigned back-to-back stream: 12, 42, 65067 from edge N+3 onward
    drive(1'b1, 8'd3,   8'd4,   1'b1, 1'b0); tick();
    drive(1'b1, 8'd5,   8'd6,   1'b0, 1'b0); tick();
    drive(1'b1, 8'd255, 8'd255, 1'b0, 1'b1); tick();
    drive(1'b0, 8'd0,   8'd0,   1'b0, 1'b0);
    check("lat_not_early", 64'(ov_u), 64'd0);
    tick();
    check("u1_valid", 64'(ov_u), 64'd1);
    check("u1_result", 64'(res_u), 64'd12);
    check("u1_last", 64'(ol_u), 64'd0);
    tick();
    check("u2_result", 64'(res_u), 64'd42);
    check("u2_last", 64'(ol_u), 64'd0);
    tick();
    check("u3_result", 64'(res_u), 64'd65067);
    check("u3_last", 64'(ol_u), 64'd1);
    tick();
    check("u_idle_valid", 64'(ov_u), 64'd0);

    // Signed: -3*4 as a one-sample accumulation, then -128*-128
    drive(1'b1, 8'hFD, 8'h04, 1'b1, 1'b1); tick();
    drive(1'b1, 8'h80, 8'h80, 1'b1, 1'b0); tick();
    drive(1'b0, 8'd0,  8'd0,  1'b0, 1'b0); tick(); tick();
    check("s1_result", 64'(res_s), 64'h0000_FFFF_FFFF_FFF4);
    check("s1_last", 64'(ol_s), 64'd1);
    tick();
    check("s2_result", 64'(res_s), 64'd16384);
    check("s2_ovf", 64'(of_s), 64'd0);
    tick();

    // 16-bit accumulator wraps; next in_first clears overflow
    drive(1'b1, 8'd255, 8'd255, 1'b1, 1'b0); tick();
    drive(1'b1, 8'd255, 8'd255, 1'b0, 1'b0); tick();
    drive(1'b1, 8'd1,   8'd1,   1'b1, 1'b1); tick();
    drive(1'b0, 8'd0,   8'd0,   1'b0, 1'b0); tick();
    check("o1_result", 64'(res_o), 64'd65025);
    check("o1_ovf", 64'(of_o), 64'd0);
    tick();
    check("o2_result", 64'(res_o), 64'd64514);
    check("o2_ovf", 64'(of_o), 64'd1);
    tick();
    check("o3_result", 64'(res_o), 64'd1);
    check("o3_ovf", 64'(of_o), 64'd0);
    tick(); tick();

    // Back-pressure with four samples in flight
    drive(1'b1, 8'd1, 8'd1, 1'b1, 1'b0); tick();
    drive(1'b1, 8'd2, 8'd2, 1'b0, 1'b0); tick();
    drive(1'b1, 8'd3, 8'd3, 1'b0, 1'b0); tick();
    drive(1'b1, 8'd4, 8'd4, 1'b0, 1'b1); tick();
    drive(1'b1, 8'd9, 8'd9, 1'b1, 1'b1);
    out_ready = 1'b0;
    #1;
    check("bp_ready_s", 64'(rdy_s), 64'd0);
    check("bp_ready_o", 64'(rdy_o), 64'd0);
    for (int i = 0; i < 5; i++) begin
      check("bp_ready_u", 64'(rdy_u), 64'd0);
      tick();
      check("bp_valid", 64'(ov_u), 64'd1);
      check("bp_frozen", 64'(res_u), 64'd1);
    end
    out_ready = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    check("bp_r2", 64'(res_u), 64'd5);
    tick();
    check("bp_r3", 64'(res_u), 64'd14);
    tick();
    check("bp_r4", 64'(res_u), 64'd30);
    check("bp_r4_last", 64'(ol_u), 64'd1);
    tick();
    check("bp_drained", 64'(ov_u), 64'd0);

    // Reset mid-stream with overflow set and samples in flight
    drive(1'b1, 8'd255, 8'd255, 1'b1, 1'b0); tick();
    drive(1'b1, 8'd255, 8'd255, 1'b0, 1'b0);
    repeat (4) tick();
    check("pre_rst_ovf", 64'(of_o), 64'd1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_result_o", 64'(res_o), 64'd0);
    check("mid_rst_ovf_o",    64'(of_o),  64'd0);
    check("mid_rst_valid_o",  64'(ov_o),  64'd0);
    check("mid_rst_result_u", 64'(res_u), 64'd0);
    check("mid_rst_valid_u",  64'(ov_u),  64'd0);
    flush_model();
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(rdy_u), 64'd1);
    drive(1'b1, 8'd2, 8'd3, 1'b0, 1'b1); tick();
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (3) tick();
    check("post_rst_result_u", 64'(res_u), 64'd6);
    check("post_rst_result_o", 64'(res_o), 64'd6);
    check("post_rst_ovf_o",    64'(of_o),  64'd0);
    check("post_rst_last",     64'(ol_u),  64'd1);
    tick();

    // Random stream with random stalls, checked by the scoreboard
    start = n_acc;
    cyc   = 0;
    while ((n_acc - start) < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      fa        = pick();
      fb        = pick();
      in_first  = ($urandom_range(7) == 0);
      in_last   = ($urandom_range(7) == 0);
      tick();
      cyc++;
    end
    check("rand_accepted", 64'(n_acc - start >= 10000), 64'd1);
    out_ready = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (8) tick();
    check("drain_u", 64'(q_u.size()), 64'd0);
    check("drain_s", 64'(q_s.size()), 64'd0);
    check("drain_o", 64'(q_o.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
